// File: rtl/mux_arb_pkg.sv
// Shared types for the two-source round-robin arbiter.
//   arb_state_e : arbiter grant state (no grant, A granted, B granted)
//   src_e       : identifies a source; used to remember who held the grant last
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

endpackage

// File: rtl/mux_m.sv
// 2:1 data multiplexer shared by the arbiter.
//   sel_a : 1 selects in_a, 0 selects in_b
//   in_a  : WIDTH-bit input A
//   in_b  : WIDTH-bit input B
//   out   : WIDTH-bit selected data (combinational)
module mux_m #(
  parameter int WIDTH = 8
) (
  input  logic             sel_a,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = sel_a ? in_a : in_b;
  end

endmodule

// File: rtl/mux_arb_rr.sv
// Two-source round-robin arbiter sharing one WIDTH-bit path between sources
// A and B, feeding a single-entry registered output stage.
//   clk, rst                    : clock, synchronous active-high reset
//   a_data/a_valid/a_ready      : source A handshake
//   b_data/b_valid/b_ready      : source B handshake
//   out_data/out_valid/out_ready: registered output handshake
//   grant_a, grant_b            : current grant status
// A granted source keeps the path until it drops valid or completes
// MAX_BURST accepted beats while the other source is waiting.
module mux_arb_rr
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             grant_a,
  output logic             grant_b
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e             state_q, state_d;
  logic       [CNT_W-1:0] cnt_q, cnt_d;
  logic       [CNT_W-1:0] cnt_inc;
  src_e                   last_q, last_d;
  logic                   out_valid_q, out_valid_d;
  logic       [WIDTH-1:0] out_data_q, out_data_d;
  logic       [WIDTH-1:0] mux_y;
  logic                   space;
  logic                   acc_a;
  logic                   acc_b;
  logic                   burst_done;

  mux_m #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel_a(grant_a),
    .in_a (a_data),
    .in_b (b_data),
    .out  (mux_y)
  );

  always_comb begin
    grant_a    = (state_q == GNT_A);
    grant_b    = (state_q == GNT_B);
    // The output register can take a beat if empty or draining this cycle.
    space      = !out_valid_q || out_ready;
    a_ready    = grant_a && space;
    b_ready    = grant_b && space;
    acc_a      = a_valid && a_ready;
    acc_b      = b_valid && b_ready;
    // cnt_q < MAX_BURST always holds, so the increment cannot overflow CNT_W.
    cnt_inc    = cnt_q + 1'b1;
    burst_done = (cnt_inc == CNT_W'(MAX_BURST));
  end

  // Output stage: load on accept, otherwise empty when downstream takes it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (acc_a || acc_b) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Grant state machine.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        // On a tie, grant the source that did not hold the path last.
        if (a_valid && (!b_valid || last_q == SRC_B)) begin
          state_d = GNT_A;
          cnt_d   = '0;
        end else if (b_valid) begin
          state_d = GNT_B;
          cnt_d   = '0;
        end
      end
      GNT_A: begin
        if (acc_a) begin
          if (burst_done) begin
            // Counter restarts even if A keeps the path (B not waiting).
            cnt_d = '0;
            if (b_valid) begin
              state_d = GNT_B;
              last_d  = SRC_A;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!a_valid) begin
          cnt_d   = '0;
          last_d  = SRC_A;
          state_d = b_valid ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (acc_b) begin
          if (burst_done) begin
            cnt_d = '0;
            if (a_valid) begin
              state_d = GNT_A;
              last_d  = SRC_B;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!b_valid) begin
          cnt_d   = '0;
          last_d  = SRC_B;
          state_d = a_valid ? GNT_A : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= SRC_B;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
module tb_mux_arb_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       a_ready_o  [2];
  logic       b_ready_o  [2];
  logic [7:0] out_data_o [2];
  logic       out_valid_o[2];
  logic       grant_a_o  [2];
  logic       grant_b_o  [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_arb_rr #(.WIDTH(8), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready_o[0]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready_o[0]),
    .out_data(out_data_o[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready),
    .grant_a(grant_a_o[0]), .grant_b(grant_b_o[0])
  );

  mux_arb_rr #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready_o[1]),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready_o[1]),
    .out_data(out_data_o[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready),
    .grant_a(grant_a_o[1]), .grant_b(grant_b_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Per instance: who owns the path (0 none, 1 A, 2 B),
  // beats taken in the current tenure, whether A held the path last, and
  // the content of the one-entry output buffer.
  int         mb     [2] = '{4, 1};
  int         own    [2] = '{0, 0};
  int         run    [2] = '{0, 0};
  bit         last_a [2] = '{1'b0, 1'b0};
  bit         ov     [2] = '{1'b0, 1'b0};
  logic [7:0] od     [2] = '{8'h00, 8'h00};

  bit m_sp, m_ra, m_rb, m_took, m_mine_v, m_oth_v;
  int m_me, m_other;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        m_sp = !ov[k] || out_ready;
        m_ra = (own[k] == 1) && m_sp;
        m_rb = (own[k] == 2) && m_sp;
        chk($sformatf("d%0d.grant_a", k),   32'(grant_a_o[k]),   32'(own[k] == 1));
        chk($sformatf("d%0d.grant_b", k),   32'(grant_b_o[k]),   32'(own[k] == 2));
        chk($sformatf("d%0d.a_ready", k),   32'(a_ready_o[k]),   32'(m_ra));
        chk($sformatf("d%0d.b_ready", k),   32'(b_ready_o[k]),   32'(m_rb));
        chk($sformatf("d%0d.out_valid", k), 32'(out_valid_o[k]), 32'(ov[k]));
        chk($sformatf("d%0d.out_data", k),  32'(out_data_o[k]),  32'(od[k]));

        if (rst) begin
          own[k] = 0; run[k] = 0; last_a[k] = 1'b0; ov[k] = 1'b0; od[k] = 8'h00;
        end else begin
          m_took = (a_valid && m_ra) || (b_valid && m_rb);
          if (a_valid && m_ra) begin
            od[k] = a_data; ov[k] = 1'b1;
          end else if (b_valid && m_rb) begin
            od[k] = b_data; ov[k] = 1'b1;
          end else if (out_ready) begin
            ov[k] = 1'b0;
          end

          if (own[k] == 0) begin
            if (a_valid && b_valid) own[k] = last_a[k] ? 2 : 1;
            else if (a_valid)       own[k] = 1;
            else if (b_valid)       own[k] = 2;
            run[k] = 0;
          end else begin
            m_me     = own[k];
            m_other  = 3 - own[k];
            m_mine_v = (m_me == 1) ? a_valid : b_valid;
            m_oth_v  = (m_me == 1) ? b_valid : a_valid;
            if (m_took) begin
              run[k]++;
              if (run[k] == mb[k]) begin
                run[k] = 0;
                if (m_oth_v) begin
                  own[k] = m_other;
                  last_a[k] = (m_me == 1);
                end
              end
            end else if (!m_mine_v) begin
              run[k] = 0;
              last_a[k] = (m_me == 1);
              own[k] = m_oth_v ? m_other : 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp4 [9] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h11};
  bit took_a, took_b;

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Reset state.
    @(negedge clk);
    chk("rst.grant_a",   32'(grant_a_o[0]),   32'h0);
    chk("rst.a_ready",   32'(a_ready_o[0]),   32'h0);
    chk("rst.out_valid", 32'(out_valid_o[0]), 32'h0);
    chk("rst.out_data",  32'(out_data_o[0]),  32'h0);

    // Both sources requesting continuously.
    tick();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'h11; b_data = 8'h22; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("tie.grant_a_b4", 32'(grant_a_o[0]), 32'h1);
    chk("tie.grant_a_b1", 32'(grant_a_o[1]), 32'h1);
    for (int i = 0; i < 9; i++) begin
      tick();
      @(negedge clk);
      chk($sformatf("burst4.beat%0d", i), 32'(out_data_o[0]), 32'(exp4[i]));
      chk($sformatf("burst4.valid%0d", i), 32'(out_valid_o[0]), 32'h1);
      chk($sformatf("alt.beat%0d", i), 32'(out_data_o[1]), (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // Reset while the output register holds a beat.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.out_valid", 32'(out_valid_o[0]), 32'h0);
    chk("midrst.grant_b",   32'(grant_b_o[0]),   32'h0);
    tick();
    @(negedge clk);
    chk("midrst.tie_to_a",  32'(grant_a_o[0]),   32'h1);

    // Randomized traffic; sources honour hold-until-accepted on the
    // MAX_BURST=4 instance, apart from occasional deliberate drops.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      took_a = a_valid && a_ready_o[0];
      took_b = b_valid && b_ready_o[0];
      @(posedge clk);
      #1;
      if (a_valid && !took_a && !rst) begin
        if ($urandom_range(15) == 0) a_valid = 1'b0;
      end else begin
        a_valid = ($urandom_range(3) != 0);
        a_data  = 8'($urandom);
      end
      if (b_valid && !took_b && !rst) begin
        if ($urandom_range(15) == 0) b_valid = 1'b0;
      end else begin
        b_valid = ($urandom_range(c % 400 < 100 ? 7 : 2) != 0);
        b_data  = 8'($urandom);
      end
      out_ready = (c % 500 < 60) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      rst = ($urandom_range(199) == 0);
    end

    rst = 1'b0;
    tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
